// File: rtl/piso_tx_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
// Holds the FSM encoding and the bit counter sizing function.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } tx_state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable shift register feeding the serial line.
// Direction is fixed at elaboration by MSB_FIRST.
module piso_shreg
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             ser
);

    logic [WIDTH-1:0] q;

    // Load a fresh word, or move the next bit into the serial position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= data;
        end else if (shift) begin
            if (MSB_FIRST) begin
                q <= {q[WIDTH-2:0], 1'b0};
            end else begin
                q <= {1'b0, q[WIDTH-1:1]};
            end
        end
    end

    assign ser = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready load handshake.
// All outputs decode from flops; no input-to-output paths.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int   WIDTH      = DEFAULT_WIDTH,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             push,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             D_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic          load;
    logic          shift;
    logic          ser;

    // Next-state decode; load and shift strobes for the datapath.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_valid) begin
                    state_nxt = SHIFT;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end else begin
                    shift = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge push or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bit counter: cleared on accept, stops at the last bit.
    always_ff @(posedge push or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    piso_shreg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shreg (
        .clk   (push),
        .rst   (reset),
        .load  (load),
        .shift (shift),
        .data  (data_in),
        .ser   (ser)
    );

    assign load_ready = (state == IDLE);
    assign bit_valid  = (state == SHIFT);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign D_out      = bit_valid ? ser : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first and LSB-first instances,
// with a simple shift-in receiver on each serial line.
module tb_piso_tx;

    logic       push;
    logic       reset;
    logic [7:0] d_m, d_l;
    logic       lv_m, lv_l;
    logic       rdy_m, dout_m, bv_m, busy_m, done_m;
    logic       rdy_l, dout_l, bv_l, busy_l, done_l;
    logic [7:0] rx_m, rx_l;

    bit         sel;
    logic       o_rdy, o_d, o_bv, o_busy, o_done;
    logic [7:0] o_rx;

    int nvec = 0;
    int nerr = 0;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
        .push       (push),
        .reset      (reset),
        .data_in    (d_m),
        .load_valid (lv_m),
        .load_ready (rdy_m),
        .D_out      (dout_m),
        .bit_valid  (bv_m),
        .busy       (busy_m),
        .done       (done_m)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
        .push       (push),
        .reset      (reset),
        .data_in    (d_l),
        .load_valid (lv_l),
        .load_ready (rdy_l),
        .D_out      (dout_l),
        .bit_valid  (bv_l),
        .busy       (busy_l),
        .done       (done_l)
    );

    initial push = 1'b0;
    always #5 push = ~push;

    // Receiver: shift in serial data on every valid bit, first bit ends at MSB.
    always @(posedge push) begin
        if (bv_m) rx_m <= {rx_m[6:0], dout_m};
        if (bv_l) rx_l <= {rx_l[6:0], dout_l};
    end

    // Select which instance the checks look at.
    always_comb begin
        o_rdy  = sel ? rdy_l  : rdy_m;
        o_d    = sel ? dout_l : dout_m;
        o_bv   = sel ? bv_l   : bv_m;
        o_busy = sel ? busy_l : busy_m;
        o_done = sel ? done_l : done_m;
        o_rx   = sel ? rx_l   : rx_m;
    end

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s (dut %0d, t=%0t): got %h, expected %h",
                     name, sel, $time, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " D_out"},      {7'b0, o_d},    8'h00);
        chk({tag, " bit_valid"},  {7'b0, o_bv},   8'h00);
        chk({tag, " busy"},       {7'b0, o_busy}, 8'h00);
        chk({tag, " done"},       {7'b0, o_done}, 8'h00);
        chk({tag, " load_ready"}, {7'b0, o_rdy},  8'h01);
    endtask

    // Drive a word so it is taken at the next edge; return #1 after it.
    task automatic accept(input bit s, input logic [7:0] w, input bit hold);
        sel = s;
        if (s) begin d_l = w; lv_l = 1'b1; end
        else   begin d_m = w; lv_m = 1'b1; end
        @(posedge push); #1;
        if (!hold) begin
            if (s) lv_l = 1'b0;
            else   lv_m = 1'b0;
        end
    endtask

    // Called #1 after the accepting edge; checks stream, done, ready.
    task automatic stream(input bit s, input logic [7:0] exp);
        sel = s;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(posedge push); #1; end
            chk($sformatf("bit%0d D_out", i), {7'b0, o_d}, {7'b0, exp[7-i]});
            chk($sformatf("bit%0d valid", i), {7'b0, o_bv}, 8'h01);
            chk($sformatf("bit%0d busy", i), {7'b0, o_busy}, 8'h01);
            chk($sformatf("bit%0d ready", i), {7'b0, o_rdy}, 8'h00);
        end
        @(posedge push); #1;
        chk("done pulse",   {7'b0, o_done}, 8'h01);
        chk("done valid",   {7'b0, o_bv},   8'h00);
        chk("done D_out",   {7'b0, o_d},    8'h00);
        chk("done busy",    {7'b0, o_busy}, 8'h01);
        chk("done ready",   {7'b0, o_rdy},  8'h00);
        @(posedge push); #1;
        chk_idle("after done");
    endtask

    typedef struct {
        bit         s;
        logic [7:0] word;
        logic [7:0] stream;
    } vec_t;

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b0, 8'hA5, 8'hA5};
        vt[1] = '{1'b1, 8'h0B, 8'hD0};
        vt[2] = '{1'b0, 8'h00, 8'h00};
        vt[3] = '{1'b0, 8'hFF, 8'hFF};
        vt[4] = '{1'b1, 8'h01, 8'h80};
        vt[5] = '{1'b1, 8'hC3, 8'hC3};

        sel = 1'b0;
        d_m = 8'h00; d_l = 8'h00;
        lv_m = 1'b0; lv_l = 1'b0;
        rx_m = 8'h00; rx_l = 8'h00;
        reset = 1'b1;

        #12;
        sel = 1'b0; chk_idle("reset msb");
        sel = 1'b1; chk_idle("reset lsb");
        #3 reset = 1'b0;
        @(negedge push);

        // Table: back-to-back words, receiver must reassemble the stream.
        for (int n = 0; n < 6; n++) begin
            accept(vt[n].s, vt[n].word, 1'b0);
            stream(vt[n].s, vt[n].stream);
            chk($sformatf("rx word %0d", n), o_rx, vt[n].stream);
        end

        // load_valid held and data_in changed mid-word.
        accept(1'b0, 8'h3C, 1'b1);
        d_m = 8'hFF;
        stream(1'b0, 8'h3C);
        chk("rx 3C", o_rx, 8'h3C);
        @(posedge push); #1;
        lv_m = 1'b0;
        chk("held accept valid", {7'b0, o_bv},  8'h01);
        chk("held accept ready", {7'b0, o_rdy}, 8'h00);
        stream(1'b0, 8'hFF);
        chk("rx FF", o_rx, 8'hFF);

        // Async reset after three bits.
        accept(1'b0, 8'hF0, 1'b0);
        @(posedge push); #1;
        @(posedge push); #1;
        #3 reset = 1'b1;
        #1;
        chk_idle("mid-word reset");
        @(posedge push); #1;
        chk("reset no done", {7'b0, o_done}, 8'h00);
        @(negedge push);
        reset = 1'b0;
        @(posedge push); #1;
        chk_idle("after reset");
        accept(1'b0, 8'h81, 1'b0);
        stream(1'b0, 8'h81);
        chk("rx 81", o_rx, 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in/serial-out transmitter. It is the sending end of the single-bit serial link whose receiver is the existing mux_dff shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per rising edge of push on D_out.
- Marks each valid bit with bit_valid and pulses done when the word is finished.
- Sits between the parallel data source and the serial line.

Parameters:
WIDTH, 8, word width in bits (≥2)
MSB_FIRST, 1, 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first
IDLE_LEVEL, 1'b0, value driven on D_out when no bit is being sent

Ports:
push  input  1  clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  parallel word to send; sampled only on an accepting edge
load_valid  input  1  source requests transfer of data_in
load_ready  output  1  transmitter can accept a word (registered)
D_out  output  1  serial data line (registered)
bit_valid  output  1  high while D_out carries a payload bit (registered)
busy  output  1  high from accept until done completes (registered)
done  output  1  one-cycle pulse after the last bit (registered)

Behaviour:
- Reset (async, reset=1):
  - State = IDLE, shift register = 0, bit counter = 0.
  - D_out = IDLE_LEVEL, bit_valid = 0, busy = 0, done = 0, load_ready = 1.
  - Outputs hold these values while reset is high.
- FSM states: IDLE, SHIFT, DONE. All outputs are decoded from registered state, so there are no combinational paths from inputs to outputs.
- IDLE:
  - load_ready = 1.
  - On the edge where load_valid=1 and load_ready=1 (edge k):
    - Capture data_in; counter = 0; go to SHIFT.
    - At the same edge, D_out takes the first bit (data_in[WIDTH-1] if MSB_FIRST, else data_in[0]).
    - bit_valid = 1, busy = 1, load_ready = 0.
- SHIFT:
  - At each edge k+i (i = 1..WIDTH-1), the shift register advances one place and D_out presents bit i of the transmit order; counter increments.
  - At edge k+WIDTH (counter = WIDTH-1 before the edge), go to DONE: D_out = IDLE_LEVEL, bit_valid = 0, done = 1, busy stays 1.
- DONE: lasts exactly one cycle. At the next edge, go to IDLE: done = 0, busy = 0, load_ready = 1.
- Throughput:
  - Each bit is valid for exactly one push period.
  - Earliest next accept is edge k+WIDTH+2, so the word period is WIDTH+2 cycles.
- Ignored inputs:
  - load_valid while load_ready=0 is ignored; no queuing and no error.
  - Changes on data_in after the accepting edge do not affect the word in flight.
- Counter:
  - Width = $clog2(WIDTH).
  - Never exceeds WIDTH-1; there is no wrap inside a word.
  - Cleared on each accept.
- Reset mid-word: the partial word is discarded immediately, with no done pulse. After release, the block is in IDLE and ready.
- Reset released on the same edge as load_valid=1: the word is accepted only if reset is low at that edge.
- Data pattern is transparent: all-zero and all-one words behave like any other.
- bit_valid is the only indication of a payload bit. D_out equal to IDLE_LEVEL does not by itself mean idle.

Decomposition:
- Package piso_tx_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} tx_state_t
  - localparam default WIDTH = 8
  - function for counter width ($clog2 wrapper)
- Optional sub-module piso_shreg: WIDTH-bit loadable shift register with load, shift and direction (MSB_FIRST) controls and a serial output. The FSM and counter stay in piso_tx.
- No other hierarchy.

Test Plan:
- Reset/idle: assert reset for 15 ns with a 10 ns push period → D_out=0, bit_valid=0, busy=0, done=0, load_ready=1. Assert reset asynchronously between edges → outputs clear before the next edge.
- Single word, MSB_FIRST=1: load 8'hA5 → D_out over 8 consecutive cycles = 1,0,1,0,0,1,0,1 with bit_valid=1; done=1 in cycle 9; load_ready=1 again in cycle 10.
- LSB_FIRST (MSB_FIRST=0): load 8'h0B → D_out = 1,1,0,1,0,0,0,0; then done pulse.
- Ignored load: hold load_valid=1 and change data_in to 8'hFF during the 8'h3C transfer → serial stream is exactly 0,0,1,1,1,1,0,0. With load_valid still held, 8'hFF is accepted exactly at edge k+10 (period 10).
- Reset mid-word: load 8'hF0, assert reset after 3 bits → D_out=0, bit_valid=0 immediately, no done pulse. Then load 8'h81 → clean 1,0,0,0,0,0,0,1.
- Loopback: drive the mux_dff receiver's D_in from D_out on the same push, sending 8'hA5 → receiver D_out = 8'hA5 after the 8 bit_valid cycles. Repeat with 8'h00 and 8'hFF back-to-back.
